// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral-side responder.
//   spi_slv_state_t : responder FSM states
//   FRAME_W_DEFAULT : default frame width in bits
//   MISO_IDLE       : level driven on MISO while no frame is active
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_slv_state_t;

  localparam int FRAME_W_DEFAULT = 8;

  localparam logic MISO_IDLE = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous SPI pin.
//   clk, rst : system clock, asynchronous active-high reset
//   din      : raw pin
//   dout     : synchronized level (SYNC_STAGES flops)
//   rise     : one-cycle strobe on a synchronized 0->1 transition
//   fall     : one-cycle strobe on a synchronized 1->0 transition
// RESET_VAL is the pin's idle level, so leaving reset never fakes an edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign dout = chain[SYNC_STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 peripheral responder running in the system clock domain.
// Receives MSB-first frames on MOSI and returns a preloaded word on MISO.
//   clk, rst      : system clock, asynchronous active-high reset
//   i_SPI_Clk     : SCLK from the master (CPOL=0, CPHA=0)
//   i_SPI_MOSI    : serial data from the master
//   i_CSelect     : chip select, active-low
//   o_SPI_MISO    : serial data to the master
//   tx_data/tx_valid/tx_ready : word for the next frame (valid/ready handshake)
//   rx_data/rx_valid          : last complete frame, one-cycle update pulse
//   busy          : a frame is in progress
//   frame_err     : one-cycle pulse, CS released mid-frame
//   tx_underrun   : one-cycle pulse, frame started with no word pending
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int FRAME_W     = FRAME_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_SPI_Clk,
  input  logic               i_SPI_MOSI,
  input  logic               i_CSelect,
  output logic               o_SPI_MISO,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               busy,
  output logic               frame_err,
  output logic               tx_underrun
);

  localparam int               CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(FRAME_W);

  spi_slv_state_t     state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] hold;
  logic               tx_pending;
  logic [FRAME_W-1:0] tx_shreg;
  logic [FRAME_W-1:0] rx_shreg;
  logic [FRAME_W-1:0] rx_next;

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  // Input synchronization and edge strobes
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .din  (i_SPI_Clk),
    .dout (sclk_lvl_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk  (clk),
    .rst  (rst),
    .din  (i_CSelect),
    .dout (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // Same depth as SCLK, so mosi_s lines up with sclk_rise.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk  (clk),
    .rst  (rst),
    .din  (i_SPI_MOSI),
    .dout (mosi_s),
    .rise (mosi_rise_unused),
    .fall (mosi_fall_unused)
  );

  assign rx_next = {rx_shreg[FRAME_W-2:0], mosi_s};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; cs_rise outranks any SCLK edge in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cs_fall) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = cs_rise ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = IDLE;
        end else if (sclk_fall && (bit_cnt == BIT_FULL) && !cs_s) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_SPI_MISO = (state == IDLE) ? MISO_IDLE : tx_shreg[FRAME_W-1];
    busy       = (state != IDLE);
    tx_ready   = ~tx_pending;
  end

  // Holding register, shift registers, bit counter and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      hold        <= '0;
      tx_pending  <= 1'b0;
      tx_shreg    <= '0;
      rx_shreg    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;

      // A word offered during LOAD lands here after LOAD has already
      // sampled tx_pending, so it waits for the following frame.
      if (tx_valid && !tx_pending) begin
        hold       <= tx_data;
        tx_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
        end
        LOAD: begin
          bit_cnt <= '0;
          if (tx_pending) begin
            tx_shreg   <= hold;
            tx_pending <= 1'b0;
          end else begin
            tx_shreg    <= '0;
            tx_underrun <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            if ((bit_cnt != '0) && (bit_cnt != BIT_FULL)) begin
              frame_err <= 1'b1;
            end
            rx_shreg <= '0;
            bit_cnt  <= '0;
          end else begin
            if (sclk_rise && (bit_cnt != BIT_FULL)) begin
              rx_shreg <= rx_next;
              bit_cnt  <= bit_cnt + CNT_W'(1);
              if (bit_cnt == BIT_FULL - CNT_W'(1)) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
              end
            end
            if (sclk_fall) begin
              // The fall after the last bit leaves MISO alone; it only
              // arms a back-to-back frame.
              if (bit_cnt != BIT_FULL) begin
                tx_shreg <= {tx_shreg[FRAME_W-2:0], 1'b0};
              end else begin
                bit_cnt <= '0;
              end
            end
          end
        end
        default: begin
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
module tb_spi_slave_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, mosi, cs;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_err, tx_underrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_slave_responder #(.FRAME_W(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_SPI_Clk   (sclk),
    .i_SPI_MOSI  (mosi),
    .i_CSelect   (cs),
    .o_SPI_MISO  (miso),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .frame_err   (frame_err),
    .tx_underrun (tx_underrun)
  );

  // Pulse monitor
  int         rx_cnt   = 0;
  int         und_cnt  = 0;
  int         ferr_cnt = 0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_q.push_back(rx_data);
    end
    if (tx_underrun) und_cnt++;
    if (frame_err) ferr_cnt++;
  end

  // Reference model: one holding slot; each frame start takes the pending
  // word or returns zero and counts an underrun.
  bit         m_pend = 1'b0;
  logic [7:0] m_hold = 8'h00;
  int         m_und  = 0;
  logic [7:0] m_rx_last = 8'h00;

  function automatic logic [7:0] model_start();
    logic [7:0] r;
    if (m_pend) begin
      r      = m_hold;
      m_pend = 1'b0;
    end else begin
      r = 8'h00;
      m_und++;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    chk("tx_ready_before_push", tx_ready, !m_pend);
    tx_data  = w;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    m_pend   = 1'b1;
    m_hold   = w;
  endtask

  // Mode-0 master: MOSI set while SCLK low, MISO sampled at the rising edge.
  task automatic frame_bits(input logic [7:0] mo, input int half, input int nbits,
                            input bit release_cs, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clk(half);
      sclk      = 1'b1;
      mi[7-i]   = miso;
      wait_clk(half);
      if (release_cs && (i == nbits - 1)) cs = 1'b1;
      sclk = 1'b0;
    end
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp);
    chk({tag, "_rx_avail"}, rx_q.size() > 0, 1);
    if (rx_q.size() > 0) chk({tag, "_rx_data"}, rx_q.pop_front(), exp);
    m_rx_last = exp;
  endtask

  task automatic single_frame(input string tag, input logic [7:0] mo, input int half);
    logic [7:0] exp, mi;
    exp = model_start();
    cs  = 1'b0;
    frame_bits(mo, half, 8, 1'b1, mi);
    wait_clk(half);
    chk({tag, "_miso_word"}, mi, exp);
    check_rx(tag, mo);
    chk({tag, "_underruns"}, und_cnt, m_und);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_miso"}, miso, 0);
    chk({tag, "_tx_ready"}, tx_ready, 1);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_tx_underrun"}, tx_underrun, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mi1, mi2, e1, e2, w;
    logic [7:0] exps[3];
    int         ferr0, rxc0, half, nfr;
    bit         found, midpush;

    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1;
    tx_valid = 1'b0; tx_data = 8'h00;
    wait_clk(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(5);

    // Preloaded word, single frame
    push(8'h3C);
    chk("t1_tx_ready_pending", tx_ready, 0);
    single_frame("t1", 8'hA5, 8);
    chk("t1_rx_data_port", rx_data, 8'hA5);
    chk("t1_tx_ready_back", tx_ready, 1);

    // Back-to-back frames under one CS, second word pushed while busy
    push(8'h81);
    cs = 1'b0;
    e1 = model_start();
    wait_clk(6);
    push(8'h7E);
    frame_bits(8'h11, 8, 8, 1'b0, mi1);
    e2 = model_start();
    frame_bits(8'h22, 8, 8, 1'b1, mi2);
    wait_clk(8);
    chk("t2_miso_first", mi1, e1);
    chk("t2_miso_second", mi2, e2);
    chk("t2_rx_count", rx_q.size(), 2);
    check_rx("t2_a", 8'h11);
    check_rx("t2_b", 8'h22);
    chk("t2_underruns", und_cnt, m_und);

    // No preload: underrun, zero returned
    single_frame("t3", 8'hFF, 8);
    chk("t3_rx_data_port", rx_data, 8'hFF);

    // CS released after 5 rises
    ferr0 = ferr_cnt;
    rxc0  = rx_cnt;
    w     = 8'($urandom);
    e1    = model_start();
    cs    = 1'b0;
    frame_bits(w, 8, 5, 1'b1, mi1);
    wait_clk(8);
    chk("t4_frame_err_pulses", ferr_cnt - ferr0, 1);
    chk("t4_no_rx_valid", rx_cnt - rxc0, 0);
    chk("t4_rx_unchanged", rx_data, m_rx_last);
    chk("t4_idle", busy, 0);
    chk("t4_miso_idle", miso, 0);
    chk("t4_partial_miso", mi1[7:3], e1[7:3]);
    chk("t4_underruns", und_cnt, m_und);

    // Reset asserted after 3 bits
    ferr0 = ferr_cnt;
    rxc0  = rx_cnt;
    e1    = model_start();
    cs    = 1'b0;
    frame_bits(8'($urandom), 8, 3, 1'b0, mi1);
    rst = 1'b1;
    wait_clk(2);
    check_reset_outputs("t5_in_reset");
    cs = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    m_pend    = 1'b0;
    m_rx_last = 8'h00;
    wait_clk(6);
    check_reset_outputs("t5_after_reset");
    chk("t5_no_frame_err", ferr_cnt - ferr0, 0);
    chk("t5_no_rx_valid", rx_cnt - rxc0, 0);
    chk("t5_underruns", und_cnt, m_und);
    single_frame("t5_next", 8'h5A, 8);

    // Handshake in the LOAD cycle is held for the next frame
    cs    = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wait_clk(1);
      if (busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_load_seen", found, 1);
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    e1 = model_start();
    wait_clk(1);
    tx_valid = 1'b0;
    m_pend   = 1'b1;
    m_hold   = 8'h99;
    w = 8'($urandom);
    frame_bits(w, 8, 8, 1'b1, mi1);
    wait_clk(8);
    chk("t6_miso_current", mi1, e1);
    check_rx("t6_cur", w);
    chk("t6_underruns", und_cnt, m_und);
    chk("t6_tx_ready_held", tx_ready, 0);
    single_frame("t6_next", 8'($urandom), 8);

    // Randomized frames against the model
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(1, 0) == 1 && !m_pend) push(8'($urandom));
      nfr     = $urandom_range(3, 1);
      half    = $urandom_range(12, 5);
      midpush = ($urandom_range(1, 0) == 1);
      cs = 1'b0;
      for (int f = 0; f < nfr; f++) begin
        exps[f] = model_start();
        if (f == 0) begin
          wait_clk(6);
          if (midpush && !m_pend) push(8'($urandom));
        end
        w = 8'($urandom);
        frame_bits(w, half, 8, (f == nfr - 1), mi1);
        chk("rand_miso_word", mi1, exps[f]);
        check_rx("rand", w);
      end
      wait_clk(10);
      chk("rand_underruns", und_cnt, m_und);
      chk("rand_idle", busy, 0);
      chk("rand_tx_ready", tx_ready, !m_pend);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
